// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: in-order queue of predicted branches, resolves head vs outcome, emits predictor updates and mispredict redirects
module branch_resolve_unit #(
    parameter int DEPTH    = 4,
    parameter int PC_W     = 32,
    parameter int GHR_BITS = 8,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pred_valid,
    input  logic [PC_W-1:0]          pred_pc,
    input  logic                     pred_taken,
    input  logic [PC_W-1:0]          pred_target,
    input  logic [GHR_BITS-1:0]      pred_ghr,
    output logic                     pred_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    input  logic [PC_W-1:0]          res_target,
    output logic                     res_ready,
    output logic                     upd_valid,
    output logic [7:0]               upd_address,
    output logic                     upd_taken,
    output logic [GHR_BITS-1:0]      upd_ghr,
    output logic                     mispredict,
    output logic [PC_W-1:0]          redirect_pc,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         branch_cnt,
    output logic [CNT_W-1:0]         miss_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [PC_W-1:0]     pc_mem  [DEPTH];
    logic                tk_mem  [DEPTH];
    logic [PC_W-1:0]     tg_mem  [DEPTH];
    logic [GHR_BITS-1:0] ghr_mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic                push, pop, miss;
    logic [PC_W-1:0]     head_pc, head_tg;
    logic                head_tk;

    assign occupancy  = count;
    assign pred_ready = count != (AW+1)'(DEPTH);
    assign res_ready  = count != '0;
    assign push       = pred_valid & pred_ready;
    assign pop        = res_valid & res_ready;
    assign head_pc    = pc_mem[rd_ptr];
    assign head_tk    = tk_mem[rd_ptr];
    assign head_tg    = tg_mem[rd_ptr];

    // Compare the head entry's prediction against the resolved outcome
    always_comb begin
        miss = (head_tk != res_taken) | (head_tk & res_taken & (head_tg != res_target));
    end

    // Entry storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]  <= pred_pc;
            tk_mem[wr_ptr]  <= pred_taken;
            tg_mem[wr_ptr]  <= pred_target;
            ghr_mem[wr_ptr] <= pred_ghr;
        end
    end

    // Queue pointers and occupancy; a mispredicting pop flushes everything younger including a same-cycle push
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (pop && miss) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Register the resolution result: one-cycle strobes, held update fields, saturating statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid   <= 1'b0;
            upd_address <= '0;
            upd_taken   <= 1'b0;
            upd_ghr     <= '0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            branch_cnt  <= '0;
            miss_cnt    <= '0;
        end else begin
            upd_valid  <= pop;
            mispredict <= pop & miss;
            if (pop) begin
                upd_address <= head_pc[7:0];
                upd_taken   <= res_taken;
                upd_ghr     <= ghr_mem[rd_ptr];
                redirect_pc <= res_taken ? res_target : head_pc + PC_W'(4);
                branch_cnt  <= &branch_cnt ? branch_cnt : branch_cnt + 1'b1;
                if (miss && !(&miss_cnt)) miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and random checks of branch_resolve_unit against a queue-based reference model
module tb_branch_resolve_unit;
    logic        clk = 0;
    logic        rst = 1;
    logic        pred_valid = 0, pred_taken = 0, res_valid = 0, res_taken = 0;
    logic [31:0] pred_pc = 0, pred_target = 0, res_target = 0;
    logic [7:0]  pred_ghr = 0;
    logic        pred_ready, res_ready, upd_valid, upd_taken, mispredict;
    logic [7:0]  upd_address, upd_ghr;
    logic [31:0] redirect_pc;
    logic [2:0]  occupancy;
    logic [15:0] branch_cnt, miss_cnt;
    logic        s_pred_ready, s_res_ready, s_upd_valid, s_upd_taken, s_mispredict;
    logic [7:0]  s_upd_address, s_upd_ghr;
    logic [31:0] s_redirect_pc;
    logic [2:0]  s_occupancy;
    logic [3:0]  s_branch_cnt, s_miss_cnt;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_ghr(pred_ghr), .pred_ready(pred_ready), .res_valid(res_valid),
        .res_taken(res_taken), .res_target(res_target), .res_ready(res_ready), .upd_valid(upd_valid),
        .upd_address(upd_address), .upd_taken(upd_taken), .upd_ghr(upd_ghr), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .occupancy(occupancy), .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
    );

    branch_resolve_unit #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_ghr(pred_ghr), .pred_ready(s_pred_ready), .res_valid(res_valid),
        .res_taken(res_taken), .res_target(res_target), .res_ready(s_res_ready), .upd_valid(s_upd_valid),
        .upd_address(s_upd_address), .upd_taken(s_upd_taken), .upd_ghr(s_upd_ghr), .mispredict(s_mispredict),
        .redirect_pc(s_redirect_pc), .occupancy(s_occupancy), .branch_cnt(s_branch_cnt), .miss_cnt(s_miss_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic        t;
        logic [31:0] tg;
        logic [7:0]  g;
    } ent_t;

    ent_t        q[$];
    int          tests = 0, fails = 0;
    logic        e_uv, e_ut, e_mis;
    logic [7:0]  e_addr, e_ghr;
    logic [31:0] e_redir;
    int          e_bcnt, e_mcnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pred_ready", pred_ready, q.size() != 4);
        chk("res_ready", res_ready, q.size() != 0);
        chk("occupancy", occupancy, q.size());
        chk("upd_valid", upd_valid, e_uv);
        chk("upd_address", upd_address, e_addr);
        chk("upd_taken", upd_taken, e_ut);
        chk("upd_ghr", upd_ghr, e_ghr);
        chk("mispredict", mispredict, e_mis);
        chk("redirect_pc", redirect_pc, e_redir);
        chk("branch_cnt", branch_cnt, e_bcnt);
        chk("miss_cnt", miss_cnt, e_mcnt);
        chk("small_branch_cnt", s_branch_cnt, e_bcnt > 15 ? 15 : e_bcnt);
        chk("small_miss_cnt", s_miss_cnt, e_mcnt > 15 ? 15 : e_mcnt);
    endtask

    task automatic cycle(input logic r, input logic pv, input logic [31:0] ppc, input logic pt,
                         input logic [31:0] ptg, input logic [7:0] pg,
                         input logic rv, input logic rt, input logic [31:0] rtg);
        bit   do_push, do_pop, miss;
        ent_t e;
        rst = r; pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg; pred_ghr = pg;
        res_valid = rv; res_taken = rt; res_target = rtg;
        do_push = pv && q.size() != 4;
        do_pop  = rv && q.size() != 0;
        @(posedge clk);
        if (r) begin
            q.delete();
            e_uv = 0; e_ut = 0; e_mis = 0; e_addr = 0; e_ghr = 0; e_redir = 0; e_bcnt = 0; e_mcnt = 0;
        end else begin
            miss = 0;
            e_uv = do_pop;
            e_mis = 0;
            if (do_pop) begin
                e = q.pop_front();
                miss = (e.t != rt) || (e.t && rt && e.tg != rtg);
                e_addr = e.pc[7:0]; e_ut = rt; e_ghr = e.g; e_mis = miss;
                e_redir = rt ? rtg : e.pc + 32'd4;
                if (e_bcnt < 65535) e_bcnt++;
                if (miss && e_mcnt < 65535) e_mcnt++;
                if (miss) q.delete();
            end
            if (do_push && !miss) q.push_back('{ppc, pt, ptg, pg});
        end
        #1;
        check_all();
    endtask

    task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tg, input logic [7:0] g);
        cycle(0, 1, pc, t, tg, g, 0, 0, 0);
    endtask

    task automatic resolve(input logic t, input logic [31:0] tg);
        cycle(0, 0, 0, 0, 0, 0, 1, t, tg);
    endtask

    logic [31:0] tgts [4] = '{32'h400, 32'h480, 32'h0, 32'h200};

    initial begin
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) resolve(1, 32'h1234);
        push(32'h0000_1040, 0, 0, 8'hA5);
        resolve(0, 0);
        push(32'h100, 0, 0, 8'h01);
        push(32'h104, 0, 0, 8'h02);
        push(32'h108, 0, 0, 8'h03);
        cycle(0, 1, 32'h10C, 0, 0, 8'h04, 1, 1, 32'h200);
        resolve(0, 0);
        push(32'h300, 1, 32'h400, 8'h10);
        resolve(1, 32'h480);
        push(32'hFFFF_FFFC, 1, 32'h0, 8'h20);
        resolve(0, 32'h0);
        for (int i = 0; i < 5; i++) push(32'h500 + 32'(i * 4), 1, 32'h600, 8'(i));
        for (int i = 0; i < 10; i++) begin
            logic [31:0] hp = q.size() != 0 ? q[0].tg : 32'h0;
            logic        ht = q.size() != 0 ? q[0].t : 1'b0;
            cycle(0, 1, 32'h700 + 32'(i * 4), 1, 32'h600, 8'(8'h40 + i), 1, ht, hp);
        end
        cycle(1, 1, 32'h800, 0, 0, 8'h55, 1, 1, 32'h0);
        push(32'h900, 0, 0, 8'h66);
        cycle(1, 0, 0, 0, 0, 0, 1, 1, 32'h0);
        resolve(1, 32'h0);
        for (int i = 0; i < 400; i++)
            cycle(0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), tgts[$urandom_range(0, 3)],
                  8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tgts[$urandom_range(0, 3)]);
        for (int i = 0; i < 20; i++) begin
            push(32'hA00 + 32'(i * 4), 0, 0, 8'(i));
            resolve(1, 32'hB00);
        end
        chk("small_miss_saturated", s_miss_cnt, 4'hF);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
